// File: rtl/s_axis_cc_adapt.sv
// Completer-completion adapter: legacy (7-series) AXIS completions in, UltraScale CC
// descriptor format out, through a registered output stage backed by one skid register.
module s_axis_cc_adapt #(
    parameter int DATA_WIDTH = 128,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                    user_clk,
    input  logic                    user_reset,
    input  logic [DATA_WIDTH-1:0]   s_axis_cc_tdata,
    input  logic [KEEP_WIDTH-1:0]   s_axis_cc_tkeep,
    input  logic                    s_axis_cc_tlast,
    output logic [3:0]              s_axis_cc_tready,
    input  logic [3:0]              s_axis_cc_tuser,
    input  logic                    s_axis_cc_tvalid,
    output logic [DATA_WIDTH-1:0]   s_axis_cc_tdata_a,
    output logic [KEEP_WIDTH/4-1:0] s_axis_cc_tkeep_a,
    output logic                    s_axis_cc_tlast_a,
    input  logic [3:0]              s_axis_cc_tready_a,
    output logic [32:0]             s_axis_cc_tuser_a,
    output logic                    s_axis_cc_tvalid_a
);
    localparam int NUM_DW = KEEP_WIDTH / 4;

    // Legacy 3-DW completion header {DW2, DW1, DW0} to 3-DW CC descriptor.
    function automatic logic [95:0] cc_remap(input logic [95:0] hdr);
        logic [31:0] l0;
        logic [31:0] l1;
        logic [31:0] l2;
        logic [12:0] byte_cnt;
        logic [10:0] dw_cnt;
        logic        locked;
        l0 = hdr[31:0];
        l1 = hdr[63:32];
        l2 = hdr[95:64];
        byte_cnt = (l1[11:0] == 12'h000) ? 13'h1000 : {1'b0, l1[11:0]};
        if (!l0[30]) begin
            dw_cnt = 11'd0;
        end else if (l0[9:0] == 10'd0) begin
            dw_cnt = 11'd1024;
        end else begin
            dw_cnt = {1'b0, l0[9:0]};
        end
        locked = (l0[30:24] == 7'h0B) || (l0[30:24] == 7'h4B);
        return {
            {1'b0, 1'b0, l0[13:12], l0[22:20], 1'b0, l1[31:16], l2[15:8]},
            {l2[31:16], 1'b0, l0[14], l1[15:13], dw_cnt},
            {2'b00, locked, byte_cnt, 6'b000000, 2'b00, 1'b0, l2[6:0]}
        };
    endfunction

    logic [DATA_WIDTH-1:0] r_out_data;
    logic [NUM_DW-1:0]     r_out_keep;
    logic                  r_out_last;
    logic                  r_out_user;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic [NUM_DW-1:0]     r_skid_keep;
    logic                  r_skid_last;
    logic                  r_skid_user;
    logic                  r_skid_valid;
    logic                  r_sop;

    logic [DATA_WIDTH-1:0] w_in_data;
    logic [NUM_DW-1:0]     w_in_keep;
    logic                  w_accept;
    logic                  w_out_free;
    logic                  w_unused;

    assign w_accept   = s_axis_cc_tvalid & ~r_skid_valid;
    assign w_out_free = ~r_out_valid | s_axis_cc_tready_a[0];
    assign w_unused   = &{1'b0, s_axis_cc_tuser[2:0], s_axis_cc_tready_a[3:1], s_axis_cc_tkeep};

    // Incoming beat as it will be stored: header lanes remapped on SOP, DW keep from byte keep.
    always_comb begin
        w_in_data = s_axis_cc_tdata;
        w_in_keep = '0;
        w_in_data[95:0] = r_sop ? cc_remap(s_axis_cc_tdata[95:0]) : s_axis_cc_tdata[95:0];
        for (int i = 0; i < NUM_DW; i++) begin
            w_in_keep[i] = s_axis_cc_tkeep[4*i];
        end
    end

    // Output register, skid register and packet-start tracking; the skid always drains first.
    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            r_out_data   <= '0;
            r_out_keep   <= '0;
            r_out_last   <= 1'b0;
            r_out_user   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_skid_data  <= '0;
            r_skid_keep  <= '0;
            r_skid_last  <= 1'b0;
            r_skid_user  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_sop        <= 1'b1;
        end else begin
            if (w_accept) begin
                r_sop <= s_axis_cc_tlast;
            end
            if (w_out_free) begin
                if (r_skid_valid) begin
                    r_out_data   <= r_skid_data;
                    r_out_keep   <= r_skid_keep;
                    r_out_last   <= r_skid_last;
                    r_out_user   <= r_skid_user;
                    r_out_valid  <= 1'b1;
                    r_skid_valid <= 1'b0;
                end else if (w_accept) begin
                    r_out_data   <= w_in_data;
                    r_out_keep   <= w_in_keep;
                    r_out_last   <= s_axis_cc_tlast;
                    r_out_user   <= s_axis_cc_tuser[3];
                    r_out_valid  <= 1'b1;
                end else begin
                    r_out_valid  <= 1'b0;
                end
            end else if (w_accept) begin
                r_skid_data  <= w_in_data;
                r_skid_keep  <= w_in_keep;
                r_skid_last  <= s_axis_cc_tlast;
                r_skid_user  <= s_axis_cc_tuser[3];
                r_skid_valid <= 1'b1;
            end
        end
    end

    assign s_axis_cc_tready   = {4{~r_skid_valid}};
    assign s_axis_cc_tdata_a  = r_out_data;
    assign s_axis_cc_tkeep_a  = r_out_keep;
    assign s_axis_cc_tlast_a  = r_out_last;
    assign s_axis_cc_tuser_a  = {32'h0000_0000, r_out_user};
    assign s_axis_cc_tvalid_a = r_out_valid;

endmodule

// File: tb/tb_s_axis_cc_adapt.sv
// Self-checking bench for s_axis_cc_adapt: directed completions plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_s_axis_cc_adapt;
    logic         user_clk = 1'b0;
    logic         user_reset;
    logic [127:0] s_axis_cc_tdata;
    logic [15:0]  s_axis_cc_tkeep;
    logic         s_axis_cc_tlast;
    logic [3:0]   s_axis_cc_tready;
    logic [3:0]   s_axis_cc_tuser;
    logic         s_axis_cc_tvalid;
    logic [127:0] s_axis_cc_tdata_a;
    logic [3:0]   s_axis_cc_tkeep_a;
    logic         s_axis_cc_tlast_a;
    logic [3:0]   s_axis_cc_tready_a;
    logic [32:0]  s_axis_cc_tuser_a;
    logic         s_axis_cc_tvalid_a;

    s_axis_cc_adapt #(.DATA_WIDTH(128), .KEEP_WIDTH(16)) dut (
        .user_clk           (user_clk),
        .user_reset         (user_reset),
        .s_axis_cc_tdata    (s_axis_cc_tdata),
        .s_axis_cc_tkeep    (s_axis_cc_tkeep),
        .s_axis_cc_tlast    (s_axis_cc_tlast),
        .s_axis_cc_tready   (s_axis_cc_tready),
        .s_axis_cc_tuser    (s_axis_cc_tuser),
        .s_axis_cc_tvalid   (s_axis_cc_tvalid),
        .s_axis_cc_tdata_a  (s_axis_cc_tdata_a),
        .s_axis_cc_tkeep_a  (s_axis_cc_tkeep_a),
        .s_axis_cc_tlast_a  (s_axis_cc_tlast_a),
        .s_axis_cc_tready_a (s_axis_cc_tready_a),
        .s_axis_cc_tuser_a  (s_axis_cc_tuser_a),
        .s_axis_cc_tvalid_a (s_axis_cc_tvalid_a)
    );

    always #5 user_clk = ~user_clk;

    typedef struct packed {
        logic [127:0] d;
        logic [3:0]   k;
        logic         l;
        logic         u;
    } beat_t;

    beat_t exp_q[$];
    int    occ = 0;
    bit    m_sop = 1'b1;
    int    checks = 0;
    int    errors = 0;
    bit    done;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Descriptor built field by field from the completion header rules.
    function automatic logic [95:0] model_remap(input logic [31:0] h0, input logic [31:0] h1,
                                                input logic [31:0] h2);
        logic [31:0] fmt_type, len, bc, dwc, lk, d0, d1, d2;
        fmt_type = (h0 >> 24) & 32'h7F;
        len      = h0 & 32'h3FF;
        bc       = h1 & 32'hFFF;
        if (bc == 32'd0) bc = 32'd4096;
        if (h0[30] == 1'b0) dwc = 32'd0;
        else if (len == 32'd0) dwc = 32'd1024;
        else dwc = len;
        lk = (fmt_type == 32'd11 || fmt_type == 32'd75) ? 32'd1 : 32'd0;
        d0 = bc * 32'd65536 + lk * 32'h2000_0000 + (h2 & 32'h7F);
        d1 = (h2 >> 16) * 32'd65536 + ((h0 >> 14) & 32'd1) * 32'd16384
           + ((h1 >> 13) & 32'd7) * 32'd2048 + dwc;
        d2 = ((h0 >> 12) & 32'd3) * 32'h1000_0000 + ((h0 >> 20) & 32'd7) * 32'h0200_0000
           + (h1 >> 16) * 32'd256 + ((h2 >> 8) & 32'hFF);
        return {d2, d1, d0};
    endfunction

    function automatic beat_t model_beat(input logic [127:0] d, input logic [15:0] k,
                                         input logic l, input logic [3:0] u, input bit sop);
        beat_t b;
        b.d = d;
        if (sop) b.d[95:0] = model_remap(d[31:0], d[63:32], d[95:64]);
        for (int i = 0; i < 4; i++) b.k[i] = k[4*i];
        b.l = l;
        b.u = u[3];
        return b;
    endfunction

    // Compare outputs against the model, then account for the handshakes of the coming edge.
    always @(negedge user_clk) begin
        beat_t h;
        check("tvalid_a_occupancy", 256'(s_axis_cc_tvalid_a), 256'(occ > 0));
        check("tready_skid", 256'(s_axis_cc_tready), (occ < 2) ? 256'hF : 256'h0);
        if (s_axis_cc_tvalid_a && exp_q.size() > 0) begin
            h = exp_q[0];
            check("tdata_a", 256'(s_axis_cc_tdata_a), 256'(h.d));
            check("tkeep_a", 256'(s_axis_cc_tkeep_a), 256'(h.k));
            check("tlast_a", 256'(s_axis_cc_tlast_a), 256'(h.l));
            check("tuser_a", 256'(s_axis_cc_tuser_a), 256'({32'h0, h.u}));
        end
        if (user_reset) begin
            exp_q.delete();
            occ   = 0;
            m_sop = 1'b1;
        end else begin
            if (s_axis_cc_tvalid_a && s_axis_cc_tready_a[0] && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                occ--;
            end
            if (s_axis_cc_tvalid && s_axis_cc_tready[0]) begin
                exp_q.push_back(model_beat(s_axis_cc_tdata, s_axis_cc_tkeep, s_axis_cc_tlast,
                                           s_axis_cc_tuser, m_sop));
                m_sop = s_axis_cc_tlast;
                occ++;
            end
        end
    end

    task automatic send_beat(input logic [127:0] d, input logic [15:0] k, input logic l,
                             input logic [3:0] u);
        bit acc = 1'b0;
        s_axis_cc_tdata  = d;
        s_axis_cc_tkeep  = k;
        s_axis_cc_tlast  = l;
        s_axis_cc_tuser  = u;
        s_axis_cc_tvalid = 1'b1;
        for (int i = 0; i < 1000 && !acc; i++) begin
            @(negedge user_clk);
            acc = s_axis_cc_tready[0];
            @(posedge user_clk);
            #1;
        end
        if (!acc) check("accept_timeout", 256'(acc), 256'd1);
    endtask

    task automatic send_pkt(input int nbeats, input logic [31:0] h0, input logic [31:0] h1,
                            input logic [31:0] h2, input bit gaps);
        logic [127:0] d;
        for (int b = 0; b < nbeats; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_axis_cc_tvalid = 1'b0;
                @(posedge user_clk);
                #1;
            end
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            if (b == 0) d[95:0] = {h2, h1, h0};
            send_beat(d, 16'($urandom()), (b == nbeats - 1), 4'($urandom()));
        end
        s_axis_cc_tvalid = 1'b0;
    endtask

    task automatic drain();
        s_axis_cc_tvalid   = 1'b0;
        s_axis_cc_tready_a = 4'hF;
        repeat (8) @(posedge user_clk);
        #1;
        check("drain_empty", 256'(exp_q.size()), 256'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        user_reset = 1'b1;
        s_axis_cc_tdata = '0;
        s_axis_cc_tkeep = '0;
        s_axis_cc_tlast = 1'b0;
        s_axis_cc_tuser = '0;
        s_axis_cc_tvalid = 1'b0;
        s_axis_cc_tready_a = 4'hF;
        repeat (2) @(posedge user_clk);
        #1;
        user_reset = 1'b0;
        check("rst_tvalid_a", 256'(s_axis_cc_tvalid_a), 256'd0);
        check("rst_tdata_a", 256'(s_axis_cc_tdata_a), 256'd0);
        check("rst_tkeep_a", 256'(s_axis_cc_tkeep_a), 256'd0);
        check("rst_tuser_a", 256'(s_axis_cc_tuser_a), 256'd0);
        check("rst_tlast_a", 256'(s_axis_cc_tlast_a), 256'd0);
        check("rst_tready", 256'(s_axis_cc_tready), 256'hF);

        // Model pinned against hand-derived descriptors.
        check("model_ur", 256'(model_remap(32'h0A00_0000, 32'h0100_2004, 32'hABCD_1200)),
              256'({32'h0001_0012, 32'hABCD_0800, 32'h0004_0000}));
        check("model_4k", 256'(model_remap(32'h4A00_0000, 32'h0, 32'h0)),
              256'({32'h0, 32'h0000_0400, 32'h1000_0000}));

        // Cpl UR, single beat.
        send_beat({32'h1111_2222, 32'hABCD_1200, 32'h0100_2004, 32'h0A00_0000}, 16'h0FFF, 1'b1, 4'h0);
        s_axis_cc_tvalid = 1'b0;
        check("ur_desc", 256'(s_axis_cc_tdata_a[95:0]),
              256'({32'h0001_0012, 32'hABCD_0800, 32'h0004_0000}));
        check("ur_keep", 256'(s_axis_cc_tkeep_a), 256'h7);
        check("ur_valid", 256'(s_axis_cc_tvalid_a), 256'd1);

        // CplD length 1 with payload in lane 3.
        send_beat({32'hDEAD_BEEF, 32'h0000_0010, 32'h0000_0004, 32'h4A00_0001}, 16'hFFFF, 1'b1, 4'h8);
        s_axis_cc_tvalid = 1'b0;
        check("cpld1_beat", 256'(s_axis_cc_tdata_a),
              256'({32'hDEAD_BEEF, 32'h0, 32'h0000_0001, 32'h0004_0010}));
        check("cpld1_last", 256'(s_axis_cc_tlast_a), 256'd1);
        check("cpld1_user", 256'(s_axis_cc_tuser_a), 256'd1);

        // CplDLk with TC=3, attr=2, EP=1.
        send_beat({32'h0, 32'h0000_0000, 32'h0000_0004, 32'h4B30_6001}, 16'hFFFF, 1'b1, 4'h0);
        s_axis_cc_tvalid = 1'b0;
        check("lk_desc", 256'(s_axis_cc_tdata_a[95:0]),
              256'({32'h2600_0000, 32'h0000_4001, 32'h2004_0000}));
        drain();

        // 4 KB completion over 257 beats.
        send_pkt(257, 32'h4A00_0000, 32'h0, 32'h0, 1'b0);
        drain();

        // Back-to-back 2-beat CplD against a 50% ready.
        done = 1'b0;
        fork
            begin
                for (int p = 0; p < 4; p++)
                    send_pkt(2, 32'h4A00_0002 | 32'($urandom_range(0, 7)) << 20,
                             32'h0100_0008, 32'h0042_0000 | 32'(p) << 8, 1'b0);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge user_clk);
                    #1;
                    s_axis_cc_tready_a = $urandom_range(0, 1) ? 4'hF : 4'h0;
                end
            end
        join
        drain();

        // Randomized packets, headers, gaps and ready.
        done = 1'b0;
        fork
            begin
                for (int p = 0; p < 30; p++)
                    send_pkt($urandom_range(1, 5), $urandom(), $urandom(), $urandom(), 1'b1);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge user_clk);
                    #1;
                    s_axis_cc_tready_a = 4'($urandom());
                end
            end
        join
        drain();

        // Reset in the middle of a packet, then a fresh Cpl must be treated as SOP.
        s_axis_cc_tready_a = 4'h0;
        send_beat({32'h5555_5555, 32'h0000_0000, 32'h0000_0008, 32'h4A00_0002}, 16'hFFFF, 1'b0, 4'h0);
        s_axis_cc_tvalid = 1'b0;
        user_reset = 1'b1;
        @(posedge user_clk);
        #1;
        user_reset = 1'b0;
        check("midrst_valid", 256'(s_axis_cc_tvalid_a), 256'd0);
        check("midrst_data", 256'(s_axis_cc_tdata_a), 256'd0);
        s_axis_cc_tready_a = 4'hF;
        send_beat({32'h0, 32'hABCD_1200, 32'h0100_2004, 32'h0A00_0000}, 16'h0FFF, 1'b1, 4'h0);
        s_axis_cc_tvalid = 1'b0;
        check("midrst_sop", 256'(s_axis_cc_tdata_a[95:0]),
              256'({32'h0001_0012, 32'hABCD_0800, 32'h0004_0000}));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
